// File: rtl/pipeline_foreground_decimate_pkg.sv
// rtl/pipeline_foreground_decimate_pkg.sv - shared scale encoding, coordinate width and FSM states
package pipeline_foreground_decimate_pkg;

  // Destination coordinate width (covers 0..1023)
  localparam int COORD_W = 10;

  // Scale encoding, shared with the read-side foreground scaler
  localparam logic [1:0] SCALE_FULL    = 2'b11;
  localparam logic [1:0] SCALE_HALF    = 2'b10;
  localparam logic [1:0] SCALE_QUARTER = 2'b01;
  localparam logic [1:0] SCALE_OFF     = 2'b00;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } fsm_state_t;

  // Right-shift applied to input coordinates for a given scale
  function automatic logic [1:0] scale_to_shift(input logic [1:0] scale);
    case (scale)
      SCALE_FULL:    return 2'd0;
      SCALE_HALF:    return 2'd1;
      SCALE_QUARTER: return 2'd2;
      default:       return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_foreground_decimate_fifo.sv
// rtl/pipeline_foreground_decimate_fifo.sv - fg_write_fifo, small synchronous write-request FIFO
module fg_write_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];

  // Fullness is judged before any same-cycle pop, so a full FIFO refuses the push
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pipeline_foreground_decimate.sv
// rtl/pipeline_foreground_decimate.sv - foreground pixel decimator emitting framebuffer writes (option FG_DECIMATE_STATS_EN)
module pipeline_foreground_decimate
  import pipeline_foreground_decimate_pkg::*;
#(
  parameter int RESOLUTION_X = 640,
  parameter int RESOLUTION_Y = 480,
  parameter int PIXEL_W      = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         ctrl_foreground_scale,
  input  logic               in_valid,
  input  logic               in_frame_start,
  input  logic               in_line_start,
  input  logic [PIXEL_W-1:0] in_pixel,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [PIXEL_W-1:0] wr_data,
  output logic               overflow,
  output logic               frame_done
`ifdef FG_DECIMATE_STATS_EN
  ,
  output logic [15:0]        drop_count,
  output logic [18:0]        kept_count
`endif
);

  localparam int ENTRY_W = 1 + 2*COORD_W + PIXEL_W;
  localparam logic [COORD_W-1:0] COORD_MAX = '1;
  localparam logic [COORD_W-1:0] RES_X_C   = COORD_W'(RESOLUTION_X);
  localparam logic [COORD_W-1:0] RES_Y_C   = COORD_W'(RESOLUTION_Y);

  fsm_state_t         state_q, state_d;
  logic [1:0]         scale_q, scale_d;
  logic [COORD_W-1:0] in_x_q, in_x_d;
  logic [COORD_W-1:0] in_y_q, in_y_d;
  logic               px_valid_q, px_valid_d;
  logic [PIXEL_W-1:0] px_data_q, px_data_d;
  logic               s1_keep_q, s1_keep_d;
  logic [ENTRY_W-1:0] s1_entry_q, s1_entry_d;
  logic               overflow_q, overflow_d;

  logic               frame_start;
  logic               accept;
  logic [1:0]         shift;
  logic [COORD_W-1:0] low_mask;
  logic [COORD_W-1:0] dest_x, dest_y;
  logic               is_last;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic               head_last;
  logic               drop;

  assign frame_start = in_valid && in_frame_start;
  // Pixels count only once a frame has started; a frame-start pixel always counts
  assign accept      = in_valid && ((state_q == RUN) || in_frame_start);

  // FSM and input coordinate tracking (stage 0)
  always_comb begin
    state_d    = state_q;
    scale_d    = scale_q;
    in_x_d     = in_x_q;
    in_y_d     = in_y_q;
    px_valid_d = accept;
    px_data_d  = in_pixel;
    if (frame_start) begin
      state_d = RUN;
      scale_d = ctrl_foreground_scale;
      in_x_d  = '0;
      in_y_d  = '0;
    end else if (accept && in_line_start) begin
      in_x_d = '0;
      in_y_d = (in_y_q == COORD_MAX) ? in_y_q : in_y_q + 1'b1;
    end else if (accept) begin
      in_x_d = (in_x_q == COORD_MAX) ? in_x_q : in_x_q + 1'b1;
    end
  end

  // Keep decision and destination address for the stage-0 pixel
  always_comb begin
    shift      = scale_to_shift(scale_q);
    low_mask   = ~(COORD_MAX << shift);
    dest_x     = in_x_q >> shift;
    dest_y     = in_y_q >> shift;
    is_last    = (dest_x == ((RES_X_C >> shift) - 1'b1)) &&
                 (dest_y == ((RES_Y_C >> shift) - 1'b1));
    s1_keep_d  = px_valid_q && (scale_q != SCALE_OFF) &&
                 (in_x_q < RES_X_C) && (in_y_q < RES_Y_C) &&
                 ((in_x_q & low_mask) == '0) && ((in_y_q & low_mask) == '0);
    s1_entry_d = {is_last, dest_x, dest_y, px_data_q};
  end

  // A stage-1 pixel meeting a full FIFO is lost; frame start clears the sticky flag
  assign drop = s1_keep_q && fifo_full;

  // Sticky overflow next-state
  always_comb begin
    overflow_d = overflow_q;
    if (frame_start) overflow_d = 1'b0;
    else if (drop)   overflow_d = 1'b1;
  end

  // Pipeline and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_FRAME;
      scale_q    <= SCALE_OFF;
      in_x_q     <= '0;
      in_y_q     <= '0;
      px_valid_q <= 1'b0;
      px_data_q  <= '0;
      s1_keep_q  <= 1'b0;
      s1_entry_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      scale_q    <= scale_d;
      in_x_q     <= in_x_d;
      in_y_q     <= in_y_d;
      px_valid_q <= px_valid_d;
      px_data_q  <= px_data_d;
      s1_keep_q  <= s1_keep_d;
      s1_entry_q <= s1_entry_d;
      overflow_q <= overflow_d;
    end
  end

  fg_write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s1_keep_q),
    .push_data (s1_entry_q),
    .pop       (wr_valid && wr_ready),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head fields are zeroed while empty so idle outputs read as 0
  assign {head_last, wr_x, wr_y, wr_data} = fifo_empty ? '0 : fifo_head;
  assign wr_valid   = !fifo_empty;
  assign frame_done = wr_valid && wr_ready && head_last;
  assign overflow   = overflow_q;

`ifdef FG_DECIMATE_STATS_EN
  logic [15:0] drop_count_q, drop_count_d;
  logic [18:0] kept_count_q, kept_count_d;

  // Per-frame drop (saturating) and accepted-push counters
  always_comb begin
    drop_count_d = drop_count_q;
    kept_count_d = kept_count_q;
    if (frame_start) begin
      drop_count_d = '0;
      kept_count_d = '0;
    end else begin
      if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 1'b1;
      if (s1_keep_q && !fifo_full)            kept_count_d = kept_count_q + 1'b1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_q <= '0;
      kept_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
      kept_count_q <= kept_count_d;
    end
  end

  assign drop_count = drop_count_q;
  assign kept_count = kept_count_q;
`endif

endmodule

// File: tb/tb_pipeline_foreground_decimate.sv
// tb/tb_pipeline_foreground_decimate.sv - self-checking bench for pipeline_foreground_decimate
module tb_pipeline_foreground_decimate;

  localparam int RX      = 40;
  localparam int RY      = 12;
  localparam int PW      = 16;
  localparam int EXTRA_X = 2;
  localparam int FULL_ROWS = RY + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    ctrl = 2'b00;
  logic          in_valid = 1'b0;
  logic          in_fs = 1'b0;
  logic          in_ls = 1'b0;
  logic [PW-1:0] in_pixel = '0;
  logic          wr_valid;
  logic          wr_ready = 1'b1;
  logic [9:0]    wr_x, wr_y;
  logic [PW-1:0] wr_data;
  logic          overflow;
  logic          frame_done;
`ifdef FG_DECIMATE_STATS_EN
  logic [15:0]   drop_count;
  logic [18:0]   kept_count;
`endif

  pipeline_foreground_decimate #(
    .RESOLUTION_X (RX),
    .RESOLUTION_Y (RY),
    .PIXEL_W      (PW),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .ctrl_foreground_scale (ctrl),
    .in_valid              (in_valid),
    .in_frame_start        (in_fs),
    .in_line_start         (in_ls),
    .in_pixel              (in_pixel),
    .wr_valid              (wr_valid),
    .wr_ready              (wr_ready),
    .wr_x                  (wr_x),
    .wr_y                  (wr_y),
    .wr_data               (wr_data),
    .overflow              (overflow),
    .frame_done            (frame_done)
`ifdef FG_DECIMATE_STATS_EN
    ,
    .drop_count            (drop_count),
    .kept_count            (kept_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]    x;
    logic [9:0]    y;
    logic [PW-1:0] d;
    logic          last;
  } wr_t;

  typedef struct {
    logic [1:0] sc;
    logic [1:0] mid;
    bit         gaps;
    int         nrows;
    int         exp_writes;
    int         exp_done;
  } row_t;

  wr_t  exp_q[$];
  row_t rows[8];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_writes = 0;
  int   n_done = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: a pixel at (x,y) is written iff inside the active area and on the decimation grid
  function automatic void model_pixel(input logic [1:0] sc, input int x, input int y, input logic [PW-1:0] d);
    int  f;
    wr_t e;
    case (sc)
      2'b11:   f = 1;
      2'b10:   f = 2;
      2'b01:   f = 4;
      default: f = 0;
    endcase
    if (f == 0 || x >= RX || y >= RY || (x % f) != 0 || (y % f) != 0) return;
    e.x    = 10'(x / f);
    e.y    = 10'(y / f);
    e.d    = d;
    e.last = ((x / f) == RX / f - 1) && ((y / f) == RY / f - 1);
    exp_q.push_back(e);
  endfunction

  // Scoreboard: every accepted write must match the head of the expected queue
  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_valid && wr_ready) begin
        n_writes++;
        if (frame_done) n_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {wr_x, wr_y, wr_data}, 36'h0_0000_0000 ^ {1'b1, 35'h0});
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_xyd", {wr_x, wr_y, wr_data}, {e.x, e.y, e.d});
          check("frame_done_on_pop", frame_done, e.last);
        end
      end else begin
        check("frame_done_idle", frame_done, 1'b0);
      end
    end
  end

  task automatic drive_px(input logic fs, input logic ls, input logic [PW-1:0] d);
    in_valid = 1'b1; in_fs = fs; in_ls = ls; in_pixel = d;
    step();
    in_valid = 1'b0; in_fs = 1'b0; in_ls = 1'b0;
  endtask

  task automatic drive_frame(input logic [1:0] sc, input logic [1:0] mid, input bit gaps, input int nrows);
    logic [PW-1:0] pix;
    ctrl = sc;
    for (int y = 0; y < nrows; y++) begin
      for (int x = 0; x < RX + EXTRA_X; x++) begin
        if (gaps) begin
          for (int k = 0; k < 3 && $urandom_range(0, 3) == 0; k++) begin
            in_valid = 1'b0;
            step();
          end
        end
        if (y == RY / 2 && x == 0) ctrl = mid;
        pix = PW'($urandom);
        model_pixel(sc, x, y, pix);
        in_valid = 1'b1;
        in_fs    = (x == 0 && y == 0);
        in_ls    = (x == 0 && y != 0);
        in_pixel = pix;
        step();
      end
    end
    in_valid = 1'b0; in_fs = 1'b0; in_ls = 1'b0;
  endtask

  task automatic run_row(input row_t r);
    drive_frame(r.sc, r.mid, r.gaps, r.nrows);
    if (r.exp_writes >= 0) begin
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
      repeat (3) step();
      check("drain", exp_q.size(), 0);
      check("write_count", n_writes, r.exp_writes);
      check("frame_done_count", n_done, r.exp_done);
      check("overflow_clean", overflow, 1'b0);
      n_writes = 0;
      n_done   = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $finish;
  end

  initial begin
    logic [PW-1:0] held;
    bit            seen;

    //              sc     mid    gaps nrows      writes      done
    rows[0] = '{2'b11, 2'b11, 1'b0, FULL_ROWS, 480,        1};
    rows[1] = '{2'b10, 2'b10, 1'b0, FULL_ROWS, 120,        1};
    rows[2] = '{2'b01, 2'b11, 1'b0, FULL_ROWS, 30,         1};
    rows[3] = '{2'b11, 2'b11, 1'b1, FULL_ROWS, 480,        1};
    rows[4] = '{2'b00, 2'b11, 1'b0, FULL_ROWS, 0,          0};
    rows[5] = '{2'b11, 2'b11, 1'b0, 5,         -1,         0};
    rows[6] = '{2'b10, 2'b10, 1'b1, FULL_ROWS, 200 + 120,  1};
    rows[7] = '{2'b01, 2'b01, 1'b1, FULL_ROWS, 30,         1};

    // Reset state
    repeat (3) step();
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_wr_xyd", {wr_x, wr_y, wr_data}, '0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Pixels before any frame start are ignored
    ctrl = 2'b11;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive_px(1'b0, (i % 5) == 0, PW'(i));
      seen |= wr_valid;
    end
    repeat (4) begin step(); seen |= wr_valid; end
    check("wait_frame_ignores", seen, 1'b0);

    // First-write latency: frame-start pixel appears on wr_* two edges later
    drive_px(1'b1, 1'b0, 16'hABCD);
    check("lat_edge0", wr_valid, 1'b0);
    step();
    check("lat_edge1", wr_valid, 1'b0);
    step();
    check("lat_edge2_valid", wr_valid, 1'b1);
    check("lat_edge2_xyd", {wr_x, wr_y, wr_data}, {10'd0, 10'd0, 16'hABCD});
    repeat (2) step();
    check("lat_drained", wr_valid, 1'b0);

    // Table of whole frames against the reference model
    mon_en = 1'b1;
    foreach (rows[i]) run_row(rows[i]);
    mon_en = 1'b0;

    // Backpressure: 10 full-scale pixels with the framebuffer stalled
    wr_ready = 1'b0;
    ctrl = 2'b11;
    for (int x = 0; x < 10; x++) drive_px(x == 0, 1'b0, PW'(100 + x));
    repeat (5) step();
    check("bp_valid", wr_valid, 1'b1);
    check("bp_head", {wr_x, wr_y, wr_data}, {10'd0, 10'd0, 16'd100});
    check("bp_overflow", overflow, 1'b1);
`ifdef FG_DECIMATE_STATS_EN
    check("bp_drop_count", drop_count, 16'd6);
    check("bp_kept_count", kept_count, 19'd4);
`endif
    held = wr_data;
    repeat (3) step();
    check("bp_stable", {wr_x, wr_y, wr_data}, {10'd0, 10'd0, held});
    wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_drain", {wr_valid, wr_x, wr_y, wr_data}, {1'b1, 10'(i), 10'd0, 16'(100 + i)});
      step();
    end
    check("bp_empty", wr_valid, 1'b0);
    drive_px(1'b1, 1'b0, 16'h0055);
    check("bp_overflow_cleared", overflow, 1'b0);
`ifdef FG_DECIMATE_STATS_EN
    check("bp_drop_cleared", drop_count, 16'd0);
`endif
    repeat (4) step();

    // Asynchronous reset mid-frame with three writes queued
    wr_ready = 1'b0;
    drive_px(1'b1, 1'b0, 16'h0001);
    drive_px(1'b0, 1'b0, 16'h0002);
    drive_px(1'b0, 1'b0, 16'h0003);
    repeat (3) step();
    check("rst_mid_queued", wr_valid, 1'b1);
    rst_n = 1'b0;
    #2;
    check("rst_mid_async_drop", wr_valid, 1'b0);
    step();
    @(negedge clk) rst_n = 1'b1;
    step();
    wr_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_px(1'b0, i == 4, PW'(i));
      seen |= wr_valid;
    end
    repeat (4) begin step(); seen |= wr_valid; end
    check("rst_mid_ignored", seen, 1'b0);
    check("rst_mid_overflow", overflow, 1'b0);

    // Recovery: a fresh frame after reset runs normally
    mon_en = 1'b1;
    run_row(rows[0]);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_foreground_decimate.md
Name: pipeline_foreground_decimate

Overview:
Write-side counterpart to the foreground scaler. Accepts the incoming foreground pixel stream, decimates it by 1, 2 or 4 in both axes, and emits compact framebuffer write requests (x, y, data) over a valid/ready handshake. A small FIFO absorbs framebuffer backpressure. Sits between the foreground capture front-end and the foreground framebuffer write arbiter.

Parameters:
RESOLUTION_X, 640, active pixels per input line
RESOLUTION_Y, 480, active lines per input frame
PIXEL_W, 16, pixel data width
FIFO_DEPTH, 4, write FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ctrl_foreground_scale  in  2  11 full, 10 half, 01 quarter, 00 disabled
in_valid  in  1  input pixel valid this cycle
in_frame_start  in  1  qualified by in_valid; this pixel is (0,0)
in_line_start  in  1  qualified by in_valid; this pixel is x=0 of the next line
in_pixel  in  PIXEL_W  input pixel data
wr_valid  out  1  write request valid
wr_ready  in  1  framebuffer accepts request
wr_x  out  10  destination x
wr_y  out  10  destination y
wr_data  out  PIXEL_W  destination pixel
overflow  out  1  sticky: pixel dropped this frame
frame_done  out  1  one-cycle pulse: last kept pixel of frame written

Behaviour:
- Reset (async, rst_n low): state WAIT_FRAME, counters 0, FIFO empty, wr_valid 0, wr_x/wr_y/wr_data 0, overflow 0, frame_done 0, latched scale 00.
- FSM: WAIT_FRAME -> RUN on in_valid && in_frame_start. RUN -> RUN on a new in_frame_start (resync). No other exits except reset.
- While in WAIT_FRAME, all input pixels are ignored.
- On frame_start: latch ctrl_foreground_scale into scale_q; in_x=0, in_y=0; overflow cleared. ctrl changes mid-frame are ignored until the next frame_start.
- in_line_start (non-frame-start): in_x=0, in_y+=1 (saturating at 1023).
- Other valid pixels: in_x+=1 (saturating at 1023).
- Shift s = 0/1/2 for scale 11/10/01.
- Keep rule: in_x<RESOLUTION_X, in_y<RESOLUTION_Y, low s bits of in_x and in_y both zero, and scale_q != 00. Destination is (in_x>>s, in_y>>s).
- Stage 1 register holds keep flag, address and data; it pushes into the FIFO the following cycle.
- Latency: a kept pixel sampled at edge N appears on wr_* at edge N+2 if the FIFO is empty.
- FIFO push is allowed only when count<FIFO_DEPTH, evaluated before a same-cycle pop. Push when full: the pixel is dropped and overflow is set.
- Pop occurs on wr_valid&&wr_ready. wr_valid = !empty. wr_* come from the FIFO head and are stable while wr_valid&&!wr_ready.
- Simultaneous push and pop when not full: count is unchanged.
- frame_done pulses on the pop of the entry with dest x=(RESOLUTION_X>>s)-1 and y=(RESOLUTION_Y>>s)-1. Each FIFO entry carries a last flag for this.
- Resync mid-frame: the FIFO is not flushed; queued writes complete; the counters restart.
- Scale 00: the block consumes input and emits no writes. overflow and frame_done stay 0.

Optional Feature:
FG_DECIMATE_STATS_EN. When defined:
- Adds output drop_count[15:0], a saturating count of dropped pixels, cleared at frame_start.
- Adds output kept_count[18:0], a count of pixels pushed into the FIFO this frame.

When undefined, neither port exists and no counter logic is built. Core behaviour is identical either way.

Decomposition:
- Shared package holds:
  - scale encoding constants SCALE_FULL/HALF/QUARTER/OFF, shared with the read-side scaler;
  - a function mapping scale to shift;
  - the coordinate width constant (10).
- One sub-module: fg_write_fifo, a synchronous FIFO (width 1+20+PIXEL_W, FIFO_DEPTH, count/full/empty). The top holds the FSM, counters and keep logic.

Test Plan:
- Scale 11, wr_ready=1, one 640x480 frame: 307200 writes. The first is (0,0) at 2 cycles after frame_start; the last is (639,479) with a frame_done pulse. overflow=0.
- Scale 10: only pixels with even x and even y are written. Input (4,6) -> write (2,3). 76800 writes total; frame_done on (319,239).
- Scale 01, ctrl switched to 11 mid-frame: writes remain at quarter scale, 19200 total. The next frame runs at full scale.
- Scale 11, wr_ready=0 for 10 cycles from frame start: 4 writes queued with wr_* held stable, 6 pixels dropped, overflow=1. With STATS_EN, drop_count=6. overflow clears at the next frame_start.
- rst_n pulsed low mid-frame with 3 entries queued: wr_valid drops to 0 immediately and the FSM returns to WAIT_FRAME. Pixels are ignored until the next frame_start.
- Scale 00, full frame: no writes, no frame_done, overflow=0.
